// File: rtl/program_loader.sv
// Boot loader: holds the cpu in reset, writes a framed byte stream into memory, then releases the cpu.
// Optional checksum byte and error state enabled by defining CHECKSUM_EN.
module program_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_to_memory,
    input  logic       cpu_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_to_memory,
    output logic       mem_write,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_LEN  = 3'd2,
        GET_DATA = 3'd3,
        GET_SUM  = 3'd4,
        RELEASE  = 3'd5,
        ERR      = 3'd6
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t END_STATE = GET_SUM;
`else
    localparam state_t END_STATE = RELEASE;
`endif

    state_t     state_r, state_next_s;
    logic [7:0] ptr_r, cnt_r, sum_r;
    logic [7:0] wr_addr_r, wr_data_r;
    logic       wr_pend_r, cpu_reset_r, done_r, error_r;
    logic       xfer_s;
    logic [7:0] sum_chk_s;

    assign rx_ready  = (state_r == GET_ADDR) || (state_r == GET_LEN) ||
                       (state_r == GET_DATA) || (state_r == GET_SUM);
    assign busy      = rx_ready || (state_r == RELEASE);
    assign xfer_s    = rx_valid && rx_ready;
    assign sum_chk_s = sum_r + rx_data;
    assign cpu_reset = cpu_reset_r;
    assign done      = done_r;
    assign error     = error_r;

    // Next-state logic for the frame parser
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) state_next_s = GET_ADDR;
                else      state_next_s = IDLE;
            end
            GET_ADDR: begin
                if (xfer_s) state_next_s = GET_LEN;
                else        state_next_s = GET_ADDR;
            end
            GET_LEN: begin
                if (xfer_s) begin
                    if (rx_data == 8'd0) state_next_s = END_STATE;
                    else                 state_next_s = GET_DATA;
                end else begin
                    state_next_s = GET_LEN;
                end
            end
            GET_DATA: begin
                if (xfer_s && (cnt_r == 8'd1)) state_next_s = END_STATE;
                else                           state_next_s = GET_DATA;
            end
`ifdef CHECKSUM_EN
            GET_SUM: begin
                if (xfer_s) begin
                    if (sum_chk_s == 8'd0) state_next_s = RELEASE;
                    else                   state_next_s = ERR;
                end else begin
                    state_next_s = GET_SUM;
                end
            end
            ERR: begin
                if (load) state_next_s = GET_ADDR;
                else      state_next_s = ERR;
            end
`endif
            RELEASE: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Memory port mux: cpu pass-through when idle, loader write register otherwise
    always_comb begin
        mem_address   = wr_addr_r;
        mem_to_memory = wr_data_r;
        mem_write     = 1'b0;
        if (state_r == IDLE) begin
            mem_address   = cpu_address;
            mem_to_memory = cpu_to_memory;
            mem_write     = cpu_write;
        end else if (state_r == ERR) begin
            mem_write     = 1'b0;
        end else begin
            mem_write     = wr_pend_r;
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= 8'd0;
            cnt_r       <= 8'd0;
            sum_r       <= 8'd0;
            wr_addr_r   <= 8'd0;
            wr_data_r   <= 8'd0;
            wr_pend_r   <= 1'b0;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cpu_reset_r <= (state_next_s != IDLE);
            done_r      <= (state_r == RELEASE);
`ifdef CHECKSUM_EN
            error_r     <= (state_next_s == ERR);
`else
            error_r     <= 1'b0;
`endif
            wr_pend_r   <= xfer_s && (state_r == GET_DATA);
            if (xfer_s) begin
                case (state_r)
                    GET_ADDR: begin
                        ptr_r <= rx_data;
                        sum_r <= rx_data;
                    end
                    GET_LEN: begin
                        cnt_r <= rx_data;
                        sum_r <= sum_chk_s;
                    end
                    GET_DATA: begin
                        wr_addr_r <= ptr_r;
                        wr_data_r <= rx_data;
                        ptr_r     <= ptr_r + 8'd1;
                        cnt_r     <= cnt_r - 8'd1;
                        sum_r     <= sum_chk_s;
                    end
                    default: begin
                        sum_r <= sum_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: pass-through vector table plus frame sequences.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset, load, rx_valid, rx_ready, cpu_write;
    logic [7:0] rx_data, cpu_address, cpu_to_memory;
    logic [7:0] mem_address, mem_to_memory;
    logic       mem_write, cpu_reset, busy, done, error;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [15:0] wlog[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .load(load),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cpu_address(cpu_address), .cpu_to_memory(cpu_to_memory), .cpu_write(cpu_write),
        .mem_address(mem_address), .mem_to_memory(mem_to_memory), .mem_write(mem_write),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    // Records loader-owned memory writes and done pulses
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_write && busy) wlog.push_back({mem_address, mem_to_memory});
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
    } pt_vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 20) begin
            cycle();
            k++;
        end
        chk("rx_ready timeout", {15'd0, rx_ready}, 16'd1);
        cycle();
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] n, input logic [7:0] d[8],
                             input bit throttle, input bit bad_sum, input string tag);
        logic [7:0] s;
        logic [7:0] ea;
        int d0;
        int k;
        s  = a + n;
        d0 = done_cnt;
        wlog.delete();
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk({tag, " cpu_reset after load"}, {15'd0, cpu_reset}, 16'd1);
        chk({tag, " busy after load"}, {15'd0, busy}, 16'd1);
        chk({tag, " error cleared"}, {15'd0, error}, 16'd0);
        send_byte(a);
        if (throttle) cycle();
        send_byte(n);
        for (int i = 0; i < int'(n); i++) begin
            if (throttle) cycle();
            send_byte(d[i]);
            s = s + d[i];
            chk({tag, " cpu_reset mid"}, {15'd0, cpu_reset}, 16'd1);
        end
`ifdef CHECKSUM_EN
        s = 8'd0 - s;
        if (bad_sum) s = s + 8'd1;
        send_byte(s);
`endif
        if (bad_sum) begin
            cycle();
            chk({tag, " error set"}, {15'd0, error}, 16'd1);
            chk({tag, " cpu held"}, {15'd0, cpu_reset}, 16'd1);
            chk({tag, " no done"}, 16'(done_cnt - d0), 16'd0);
            chk({tag, " rx_ready in err"}, {15'd0, rx_ready}, 16'd0);
        end else begin
            k = 0;
            while (!done && k < 8) begin
                cycle();
                k++;
            end
            chk({tag, " done"}, {15'd0, done}, 16'd1);
            chk({tag, " cpu released"}, {15'd0, cpu_reset}, 16'd0);
            chk({tag, " busy off"}, {15'd0, busy}, 16'd0);
            cycle();
            chk({tag, " done pulse width"}, {15'd0, done}, 16'd0);
            chk({tag, " done count"}, 16'(done_cnt - d0), 16'd1);
        end
        chk({tag, " write count"}, 16'(wlog.size()), 16'(n));
        for (int i = 0; i < int'(n) && i < wlog.size(); i++) begin
            ea = a + 8'(i);
            chk({tag, " write"}, wlog[i], {ea, d[i]});
        end
    endtask

    initial begin
        pt_vec_t    vecs[4];
        logic [7:0] fd[8];
        logic [7:0] fz[8];
        vecs[0] = '{addr: 8'h10, data: 8'h5A, wr: 1'b1};
        vecs[1] = '{addr: 8'hFF, data: 8'h00, wr: 1'b0};
        vecs[2] = '{addr: 8'h00, data: 8'hFF, wr: 1'b1};
        vecs[3] = '{addr: 8'h81, data: 8'h7E, wr: 1'b0};
        fz = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        reset = 1'b1; load = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_address = 8'h00; cpu_to_memory = 8'h00; cpu_write = 1'b0;
        cycle();
        cycle();
        chk("reset cpu_reset", {15'd0, cpu_reset}, 16'd1);
        chk("reset rx_ready", {15'd0, rx_ready}, 16'd0);
        chk("reset busy", {15'd0, busy}, 16'd0);
        chk("reset done", {15'd0, done}, 16'd0);
        chk("reset error", {15'd0, error}, 16'd0);
        chk("reset mem_write", {15'd0, mem_write}, 16'd0);
        reset = 1'b0;
        cycle();
        chk("cpu_reset after reset", {15'd0, cpu_reset}, 16'd0);

        for (int i = 0; i < 4; i++) begin
            cpu_address   = vecs[i].addr;
            cpu_to_memory = vecs[i].data;
            cpu_write     = vecs[i].wr;
            #1;
            chk("pt mem_address", {8'd0, mem_address}, {8'd0, vecs[i].addr});
            chk("pt mem_to_memory", {8'd0, mem_to_memory}, {8'd0, vecs[i].data});
            chk("pt mem_write", {15'd0, mem_write}, {15'd0, vecs[i].wr});
            chk("pt busy", {15'd0, busy}, 16'd0);
            cycle();
        end

        // cpu keeps driving during the load; the loader must ignore it
        cpu_address = 8'h99; cpu_to_memory = 8'hEE; cpu_write = 1'b1;
        fd = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(8'h20, 8'd3, fd, 1'b0, 1'b0, "basic");
        cpu_write = 1'b0;

`ifdef CHECKSUM_EN
        run_frame(8'h20, 8'd3, fd, 1'b0, 1'b1, "badsum");
        run_frame(8'h20, 8'd3, fd, 1'b0, 1'b0, "after_err");
`endif

        fd = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(8'hFE, 8'd3, fd, 1'b1, 1'b0, "wrap");
        run_frame(8'h40, 8'd0, fz, 1'b0, 1'b0, "zero");

        // reset in the middle of the data phase
        wlog.delete();
        load = 1'b1;
        cycle();
        load = 1'b0;
        send_byte(8'h60);
        send_byte(8'd4);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        cycle();
        chk("midrst busy", {15'd0, busy}, 16'd0);
        chk("midrst mem_write", {15'd0, mem_write}, 16'd0);
        chk("midrst rx_ready", {15'd0, rx_ready}, 16'd0);
        reset = 1'b0;
        cycle();
        chk("midrst cpu released", {15'd0, cpu_reset}, 16'd0);
        chk("midrst writes", 16'(wlog.size()), 16'd2);

        fd = '{8'h5C, 8'h6D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(8'h70, 8'd2, fd, 1'b0, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
